// File: rtl/flag_unit.sv
// ---------------------------------------------------------------------------
// flag_unit
//
// Purpose:
//   FLAG register and branch-condition evaluator for the Execute stage.
//   It derives N/V/Z from the ALU operands and result. It holds them in a
//   stateful register that each opcode updates through its own mask. It keeps
//   a one-entry checkpoint that is restored on a pipeline flush. It resolves
//   the eight branch conditions.
//
// Configuration macro:
//   FLAG_BYPASS_EN - when defined, br_taken_o evaluates the next-state flags:
//                    a committing update is merged through its mask. A branch
//                    in the same cycle as the flag-setting ALU op therefore
//                    sees the new flags. When undefined, br_taken_o evaluates
//                    the registered flags only.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   ex_valid_i    in   ALU result on ex_* is valid this cycle
//   ex_opcode_i   in   [3:0] opcode (ADD 0, SUB 1, XOR 2, RED 3, SLL 4,
//                      SRA 5, ROR 6, PADDSB 7, others non-ALU)
//   ex_op_a_i     in   [WIDTH-1:0] ALU operand A
//   ex_op_b_i     in   [WIDTH-1:0] ALU operand B
//   ex_result_i   in   [WIDTH-1:0] ALU result as written back (ADD/SUB saturated)
//   stall_i       in   hold all state this cycle
//   flush_i       in   squash the in-flight update and restore the checkpoint
//   ckpt_i        in   snapshot the FLAG register (a branch was issued)
//   br_cond_i     in   [2:0] branch condition code
//   flags_o       out  [2:0] FLAG register {N, V, Z}
//   br_taken_o    out  branch condition is true (combinational)
//   ckpt_valid_o  out  the checkpoint holds a snapshot
//
// Qualifiers: there is no backpressure. An ALU update is accepted in any cycle
// where ex_valid_i & ~stall_i & ~flush_i holds. A checkpoint is accepted under
// ckpt_i & ~stall_i & ~flush_i. flush_i takes priority over everything else.
// ---------------------------------------------------------------------------
module flag_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic [3:0]       ex_opcode_i,
  input  logic [WIDTH-1:0] ex_op_a_i,
  input  logic [WIDTH-1:0] ex_op_b_i,
  input  logic [WIDTH-1:0] ex_result_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             ckpt_i,
  input  logic [2:0]       br_cond_i,
  output logic [2:0]       flags_o,
  output logic             br_taken_o,
  output logic             ckpt_valid_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  // Bit positions inside the {N, V, Z} vector
  localparam int FN = 2;
  localparam int FV = 1;
  localparam int FZ = 0;

  logic [2:0]       flags_q, flags_d;
  logic [2:0]       shadow_q, shadow_d;
  logic             ckpt_valid_q, ckpt_valid_d;

  logic [WIDTH-1:0] raw_add, raw_sub;
  logic             a_msb, b_msb;
  logic             v_add, v_sub;
  logic             wr_n, wr_v, wr_z;
  logic             v_new;
  logic [2:0]       upd_flags;
  logic             commit;
  logic [2:0]       eval_flags;

  // V comes from the wrapped raw value. ex_result_i may already be saturated,
  // so the overflow cannot be seen in the result itself.
  assign raw_add = ex_op_a_i + ex_op_b_i;
  assign raw_sub = ex_op_a_i - ex_op_b_i;
  assign a_msb   = ex_op_a_i[WIDTH-1];
  assign b_msb   = ex_op_b_i[WIDTH-1];
  assign v_add   = (a_msb == b_msb) & (raw_add[WIDTH-1] != a_msb);
  assign v_sub   = (a_msb != b_msb) & (raw_sub[WIDTH-1] != a_msb);

  // Per-opcode write mask
  always_comb begin
    wr_n  = 1'b0;
    wr_v  = 1'b0;
    wr_z  = 1'b0;
    v_new = 1'b0;
    case (ex_opcode_i)
      OP_ADD: begin
        wr_n  = 1'b1;
        wr_v  = 1'b1;
        wr_z  = 1'b1;
        v_new = v_add;
      end
      OP_SUB: begin
        wr_n  = 1'b1;
        wr_v  = 1'b1;
        wr_z  = 1'b1;
        v_new = v_sub;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_z = 1'b1;
      default: ;
    endcase
  end

  // Merge the new bits over the current register; bits outside the mask keep their value
  assign upd_flags[FN] = wr_n ? ex_result_i[WIDTH-1]    : flags_q[FN];
  assign upd_flags[FV] = wr_v ? v_new                   : flags_q[FV];
  assign upd_flags[FZ] = wr_z ? (ex_result_i == '0)     : flags_q[FZ];

  assign commit = ex_valid_i & ~stall_i & ~flush_i;

  // Next-state logic
  always_comb begin
    flags_d      = flags_q;
    shadow_d     = shadow_q;
    ckpt_valid_d = ckpt_valid_q;
    if (flush_i) begin
      // Flush overrides stall and discards any same-cycle update or ckpt
      if (ckpt_valid_q) flags_d = shadow_q;
      ckpt_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (ckpt_i) begin
        // The snapshot takes the value before this cycle's update
        shadow_d     = flags_q;
        ckpt_valid_d = 1'b1;
      end
      if (commit) flags_d = upd_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= 3'b000;
      shadow_q     <= 3'b000;
      ckpt_valid_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      shadow_q     <= shadow_d;
      ckpt_valid_q <= ckpt_valid_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  // Forward only a committing update. A flush restore is not forwarded.
  assign eval_flags = commit ? upd_flags : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  // Branch condition decode
  always_comb begin
    br_taken_o = 1'b0;
    case (br_cond_i)
      3'b000: br_taken_o = ~eval_flags[FZ];
      3'b001: br_taken_o =  eval_flags[FZ];
      3'b010: br_taken_o = ~eval_flags[FZ] & ~eval_flags[FN];
      3'b011: br_taken_o =  eval_flags[FN];
      3'b100: br_taken_o =  eval_flags[FZ] | ~eval_flags[FN];
      3'b101: br_taken_o =  eval_flags[FN] |  eval_flags[FZ];
      3'b110: br_taken_o =  eval_flags[FV];
      default: br_taken_o = 1'b1;
    endcase
  end

  assign flags_o      = flags_q;
  assign ckpt_valid_o = ckpt_valid_q;

endmodule

// File: tb/tb_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_flag_unit
//
// Purpose:
//   Directed-vector bench for flag_unit with WIDTH = 16. A signed-arithmetic
//   reference model follows the DUT every cycle. Hand-computed literal checks
//   pin the model to known values. When FLAG_BYPASS_EN is defined, the
//   same-cycle branch expectation changes to match the forwarding behaviour.
// ---------------------------------------------------------------------------
module tb_flag_unit;

  localparam int W = 16;

  localparam logic [3:0] ADD    = 4'b0000;
  localparam logic [3:0] SUB    = 4'b0001;
  localparam logic [3:0] XOR    = 4'b0010;
  localparam logic [3:0] RED    = 4'b0011;
  localparam logic [3:0] PADDSB = 4'b0111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         ex_valid = 1'b0;
  logic [3:0]   ex_opcode = '0;
  logic [W-1:0] ex_op_a = '0, ex_op_b = '0, ex_result = '0;
  logic         stall = 1'b0, flush = 1'b0, ckpt = 1'b0;
  logic [2:0]   br_cond = '0;
  logic [2:0]   flags;
  logic         br_taken, ckpt_valid;

  flag_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid),
    .ex_opcode_i  (ex_opcode),
    .ex_op_a_i    (ex_op_a),
    .ex_op_b_i    (ex_op_b),
    .ex_result_i  (ex_result),
    .stall_i      (stall),
    .flush_i      (flush),
    .ckpt_i       (ckpt),
    .br_cond_i    (br_cond),
    .flags_o      (flags),
    .br_taken_o   (br_taken),
    .ckpt_valid_o (ckpt_valid)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The flags are three independent booleans. V is a signed-range test on
  // integers, not a bit test.
  logic m_n, m_v, m_z;
  logic [2:0] m_sh;
  logic m_cv;

  function automatic logic [2:0] model_upd(input logic [3:0] opc, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] res,
                                           input logic [2:0] cur);
    int sa, sb, r, lo, hi;
    logic [2:0] nf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    lo = -(1 << (W-1));
    hi = (1 << (W-1)) - 1;
    nf = cur;
    if (opc == ADD || opc == SUB) begin
      r = (opc == ADD) ? sa + sb : sa - sb;
      nf[2] = ($signed(res) < 0);
      nf[1] = (r > hi) || (r < lo);
      nf[0] = (res == 0);
    end else if (opc == XOR || opc == 4'd4 || opc == 4'd5 || opc == 4'd6) begin
      nf[0] = (res == 0);
    end
    return nf;
  endfunction

  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    {n, v, z} = f;
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_n, m_v, m_z} = 3'b000;
      m_sh = 3'b000;
      m_cv = 1'b0;
    end else if (flush) begin
      if (m_cv) {m_n, m_v, m_z} = m_sh;
      m_cv = 1'b0;
    end else if (!stall) begin
      if (ckpt) begin
        m_sh = {m_n, m_v, m_z};
        m_cv = 1'b1;
      end
      if (ex_valid) {m_n, m_v, m_z} = model_upd(ex_opcode, ex_op_a, ex_op_b, ex_result, {m_n, m_v, m_z});
    end
  end

  function automatic logic [2:0] model_eval();
`ifdef FLAG_BYPASS_EN
    if (ex_valid && !stall && !flush)
      return model_upd(ex_opcode, ex_op_a, ex_op_b, ex_result, {m_n, m_v, m_z});
`endif
    return {m_n, m_v, m_z};
  endfunction

  // ---------------- compare process (every cycle, away from posedge) ----------------
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_flags", flags, {m_n, m_v, m_z});
      chk("model_ckpt_valid", {2'b00, ckpt_valid}, {2'b00, m_cv});
      chk("model_br_taken", {2'b00, br_taken}, {2'b00, cond_true(br_cond, model_eval())});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [3:0] opc, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic st,
                       input logic fl, input logic ck, input logic [2:0] c);
    ex_valid = v; ex_opcode = opc; ex_op_a = a; ex_op_b = b; ex_result = res;
    stall = st; flush = fl; ckpt = ck; br_cond = c;
  endtask

  task automatic idle(input logic [2:0] c);
    drive(1'b0, 4'hF, '0, '0, '0, 1'b0, 1'b0, 1'b0, c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle(3'b000);
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_flags", flags, 3'b000);
    chk("reset_ckpt_valid", {2'b00, ckpt_valid}, 3'b000);

    // The ADD positive overflow saturates the result, but V must still be set
    drive(1, ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 0, 0, 3'b000);
    tick();
    chk("add_ovf_flags", flags, 3'b010);
    idle(3'b110); #1;
    chk("br_ovfl", {2'b00, br_taken}, 3'b001);

    // most-negative + most-negative
    drive(1, ADD, 16'h8000, 16'h8000, 16'h8000, 0, 0, 0, 3'b000);
    tick();
    chk("add_minmin_flags", flags, 3'b110);
    // 0 - most-negative
    drive(1, SUB, 16'h0000, 16'h8000, 16'h7FFF, 0, 0, 0, 3'b000);
    tick();
    chk("sub_0_min_flags", flags, 3'b010);
    // Back to N=1,V=1. The ckpt in this cycle snapshots the pre-update value.
    drive(1, ADD, 16'h8000, 16'h8000, 16'h8000, 0, 0, 1, 3'b000);
    tick();
    chk("nv_set_flags", flags, 3'b110);
    chk("ckpt_set", {2'b00, ckpt_valid}, 3'b001);
    drive(1, XOR, 16'h00FF, 16'h00FF, 16'h0000, 0, 0, 0, 3'b000);
    tick();
    chk("xor_z_only", flags, 3'b111);
    drive(1, RED, 16'h0001, 16'h0002, 16'h0000, 0, 0, 0, 3'b000);
    tick();
    chk("red_no_write", flags, 3'b111);
    drive(1, PADDSB, 16'h0101, 16'h0101, 16'h0202, 0, 0, 0, 3'b000);
    tick();
    chk("paddsb_no_write", flags, 3'b111);
    drive(1, 4'hC, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3'b000);
    tick();
    chk("nonalu_no_write", flags, 3'b111);

    // Asynchronous reset in the middle of the cycle
    idle(3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags", flags, 3'b000);
    chk("async_rst_ckpt_valid", {2'b00, ckpt_valid}, 3'b000);
    tick();
    rst_n = 1'b1;

    // A stalled SUB must not update the flags
    drive(1, SUB, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 3'b000);
    tick();
    chk("stall_hold", flags, 3'b000);
    drive(1, SUB, 16'h0005, 16'h0005, 16'h0000, 0, 0, 0, 3'b000);
    tick();
    chk("sub_zero", flags, 3'b001);
    idle(3'b100); #1;
    chk("br_gte", {2'b00, br_taken}, 3'b001);
    idle(3'b101); #1;
    chk("br_lte", {2'b00, br_taken}, 3'b001);
    idle(3'b010); #1;
    chk("br_gt", {2'b00, br_taken}, 3'b000);

    // Checkpoint then restore on flush
    drive(1, ADD, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 3'b000);
    tick();
    chk("add_clear", flags, 3'b000);
    drive(0, 4'hF, '0, '0, '0, 0, 0, 1, 3'b011);
    tick();
    chk("ckpt_valid_1", {2'b00, ckpt_valid}, 3'b001);
    drive(1, SUB, 16'h0001, 16'h0002, 16'hFFFF, 0, 0, 0, 3'b011);
    tick();
    chk("sub_neg", flags, 3'b100);
    drive(0, 4'hF, '0, '0, '0, 0, 1, 0, 3'b011);
    tick();
    chk("flush_restore", flags, 3'b000);
    chk("flush_clears_cv", {2'b00, ckpt_valid}, 3'b000);
    drive(1, SUB, 16'h0001, 16'h0002, 16'hFFFF, 0, 0, 0, 3'b011);
    tick();
    chk("sub_neg2", flags, 3'b100);
    // A flush with no snapshot leaves the flags as they are and discards the update and the ckpt
    drive(1, ADD, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 3'b011);
    tick();
    chk("flush_no_ckpt", flags, 3'b100);
    chk("flush_no_ckpt_cv", {2'b00, ckpt_valid}, 3'b000);

    // Flush overrides stall
    drive(0, 4'hF, '0, '0, '0, 0, 0, 1, 3'b000);
    tick();
    drive(1, ADD, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3'b000);
    tick();
    chk("add_zero", flags, 3'b001);
    drive(0, 4'hF, '0, '0, '0, 1, 1, 0, 3'b000);
    tick();
    chk("flush_over_stall", flags, 3'b100);
    chk("flush_over_stall_cv", {2'b00, ckpt_valid}, 3'b000);

    // Same-cycle branch on the flag-setting ADD
    drive(1, ADD, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 0, 3'b001);
    #1;
`ifdef FLAG_BYPASS_EN
    chk("br_eq_same_cycle", {2'b00, br_taken}, 3'b001);
`else
    chk("br_eq_same_cycle", {2'b00, br_taken}, 3'b000);
`endif
    tick();
    idle(3'b001); #1;
    chk("br_eq_next_cycle", {2'b00, br_taken}, 3'b001);
    chk("add_wrap_zero", flags, 3'b001);

    // A stalled update is never forwarded
    drive(1, SUB, 16'h0001, 16'h0002, 16'hFFFF, 1, 0, 0, 3'b011);
    #1;
    chk("br_lt_stalled", {2'b00, br_taken}, 3'b000);
    tick();
    idle(3'b111);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
